// File: rtl/data_memory_pkg.sv
// Shared encodings, FSM states and the read-request record for the bytewise data memory.
package data_memory_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE    = 2'b00,
    SIZE_HALF    = 2'b01,
    SIZE_WORD    = 2'b10,
    SIZE_ILLEGAL = 2'b11
  } access_size_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int INIT_INDEX = 0;
  localparam int INIT_ZERO  = 1;

  // One in-flight load: raw word captured at the accept edge plus everything needed to finish it.
  typedef struct packed {
    logic         valid;
    logic [31:0]  word;
    logic [1:0]   offset;
    access_size_e size;
    logic         load_unsigned;
    logic         misaligned;
    logic         out_of_range;
  } rd_req_t;

  function automatic logic is_misaligned(input access_size_e size, input logic [1:0] offset);
    logic mis;
    case (size)
      SIZE_BYTE: mis = 1'b0;
      SIZE_HALF: mis = offset[0];
      SIZE_WORD: mis = (offset != 2'b00);
      default:   mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Selects the addressed byte/half lane of a loaded word and sign- or zero-extends it.
module mem_load_align
  import data_memory_pkg::*;
(
  input  logic [31:0]  rd_word,
  input  logic [1:0]   offset,
  input  access_size_e size,
  input  logic         load_unsigned,
  output logic [31:0]  result
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension; an illegal size yields zero.
  always_comb begin
    byte_s = rd_word[{offset, 3'b000} +: 8];
    half_s = offset[1] ? rd_word[31:16] : rd_word[15:0];
    result = 32'h0000_0000;
    case (size)
      SIZE_BYTE: result = load_unsigned ? {24'h00_0000, byte_s} : {{24{byte_s[7]}}, byte_s};
      SIZE_HALF: result = load_unsigned ? {16'h0000, half_s} : {{16{half_s[15]}}, half_s};
      SIZE_WORD: result = rd_word;
      default:   result = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_memory_bytewise.sv
// Byte/half/word data memory with post-reset init sweep, lane-masked stores,
// pipelined extended loads and misaligned/out-of-range flagging.
module data_memory_bytewise
  import data_memory_pkg::*;
#(
  parameter int DEPTH        = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter int INIT_MODE    = INIT_INDEX
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  memRead,
  input  logic                  memWrite,
  input  logic [1:0]            accessSize,
  input  logic                  loadUnsigned,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           writeData,
  output logic [31:0]           readData,
  output logic                  readValid,
  output logic                  memReady,
  output logic                  misaligned,
  output logic                  outOfRange
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int AIW   = ADDR_WIDTH - 2;
  localparam logic [AIW-1:0]   LAST_IDX  = AIW'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(DEPTH - 1);

  logic [31:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  init_count_q, init_count_d;
  logic              mem_ready_q, mem_ready_d;
  logic [31:0]       read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              misaligned_q, misaligned_d;
  logic              out_of_range_q, out_of_range_d;

  logic [1:0]        offset_s;
  logic [AIW-1:0]    word_idx_s;
  logic [IDX_W-1:0]  mem_idx_s;
  access_size_e      size_s;
  logic              mis_s, oor_s, wr_seen_s, wr_accept_s;
  logic [3:0]        wr_mask_s;
  logic [31:0]       wr_lanes_s, init_word_s, aligned_s;
  rd_req_t           req_s, out_req_s;

  // Address decode, legality and request capture.
  always_comb begin
    offset_s    = address[1:0];
    word_idx_s  = address[ADDR_WIDTH-1:2];
    mem_idx_s   = word_idx_s[IDX_W-1:0];
    size_s      = access_size_e'(accessSize);
    mis_s       = is_misaligned(size_s, offset_s);
    oor_s       = !mis_s && (word_idx_s > LAST_IDX);
    wr_seen_s   = memWrite && mem_ready_q;
    wr_accept_s = wr_seen_s && !mis_s && !oor_s;
    init_word_s = (INIT_MODE == INIT_ZERO) ? 32'h0000_0000 : 32'(init_count_q);

    req_s.valid         = memRead && mem_ready_q;
    req_s.word          = mem_q[mem_idx_s];
    req_s.offset        = offset_s;
    req_s.size          = size_s;
    req_s.load_unsigned = loadUnsigned;
    req_s.misaligned    = mis_s;
    req_s.out_of_range  = oor_s;
  end

  // Store lane mask and replicated store data.
  always_comb begin
    wr_mask_s  = 4'b0000;
    wr_lanes_s = writeData;
    case (size_s)
      SIZE_BYTE: begin
        wr_mask_s  = 4'b0001 << offset_s;
        wr_lanes_s = {4{writeData[7:0]}};
      end
      SIZE_HALF: begin
        wr_mask_s  = 4'b0011 << offset_s;
        wr_lanes_s = {2{writeData[15:0]}};
      end
      SIZE_WORD: begin
        wr_mask_s  = 4'b1111;
        wr_lanes_s = writeData;
      end
      default: begin
        wr_mask_s  = 4'b0000;
        wr_lanes_s = writeData;
      end
    endcase
  end

  // Storage array: sweep writes during init, lane-masked stores afterwards.
  always_ff @(posedge clock) begin
    if (state_q == ST_INIT) begin
      mem_q[init_count_q] <= init_word_s;
    end else if (wr_accept_s) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_mask_s[b]) begin
          mem_q[mem_idx_s][8*b +: 8] <= wr_lanes_s[8*b +: 8];
        end
      end
    end
  end

  // Init sweep FSM.
  always_comb begin
    state_d      = state_q;
    init_count_d = init_count_q;
    mem_ready_d  = mem_ready_q;
    case (state_q)
      ST_INIT: begin
        mem_ready_d = 1'b0;
        if (init_count_q == LAST_INIT) begin
          state_d      = ST_RUN;
          init_count_d = '0;
          mem_ready_d  = 1'b1;
        end else begin
          init_count_d = init_count_q + 1'b1;
        end
      end
      ST_RUN: begin
        mem_ready_d = 1'b1;
      end
      default: begin
        state_d      = ST_INIT;
        init_count_d = '0;
        mem_ready_d  = 1'b0;
      end
    endcase
  end

  // The word is read at the accept edge, so a same-cycle store is seen only by later loads.
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign out_req_s = req_s;
    end else begin : g_lat2
      rd_req_t pipe_q;

      // Extra read stage for the two-cycle configuration.
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          pipe_q <= '0;
        end else begin
          pipe_q <= req_s;
        end
      end

      assign out_req_s = pipe_q;
    end
  endgenerate

  mem_load_align u_load_align (
    .rd_word       (out_req_s.word),
    .offset        (out_req_s.offset),
    .size          (out_req_s.size),
    .load_unsigned (out_req_s.load_unsigned),
    .result        (aligned_s)
  );

  // Output data, valid pulse and flag merging of read and write sides.
  always_comb begin
    read_valid_d   = out_req_s.valid;
    read_data_d    = read_data_q;
    if (out_req_s.valid) begin
      read_data_d = (out_req_s.misaligned || out_req_s.out_of_range) ? 32'h0000_0000 : aligned_s;
    end else begin
      read_data_d = read_data_q;
    end
    misaligned_d   = (out_req_s.valid && out_req_s.misaligned) || (wr_seen_s && mis_s);
    out_of_range_d = (out_req_s.valid && out_req_s.out_of_range) || (wr_seen_s && oor_s);
  end

  // Control and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_INIT;
      init_count_q   <= '0;
      mem_ready_q    <= 1'b0;
      read_data_q    <= 32'h0000_0000;
      read_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_count_q   <= init_count_d;
      mem_ready_q    <= mem_ready_d;
      read_data_q    <= read_data_d;
      read_valid_q   <= read_valid_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  assign readData   = read_data_q;
  assign readValid  = read_valid_q;
  assign memReady   = mem_ready_q;
  assign misaligned = misaligned_q;
  assign outOfRange = out_of_range_q;

endmodule

// File: tb/tb_data_memory_bytewise.sv
// Directed bench: latency-1 instance for load/store behaviour, latency-2 instance for pipelining and reset recovery.
module tb_data_memory_bytewise;

  logic        clock = 1'b0;
  logic        rst, rst2;
  logic        mem_read, mem_write, load_unsigned;
  logic [1:0]  access_size;
  logic [31:0] address, write_data;

  logic [31:0] r1_data, r2_data;
  logic        r1_valid, r1_ready, r1_mis, r1_oor;
  logic        r2_valid, r2_ready, r2_mis, r2_oor;

  int checks = 0;
  int errors = 0;
  int n;
  logic seen;

  always #5 clock = ~clock;

  data_memory_bytewise #(.DEPTH(32), .ADDR_WIDTH(32), .READ_LATENCY(1), .INIT_MODE(0)) dut1 (
    .clock(clock), .reset(rst), .memRead(mem_read), .memWrite(mem_write),
    .accessSize(access_size), .loadUnsigned(load_unsigned), .address(address),
    .writeData(write_data), .readData(r1_data), .readValid(r1_valid),
    .memReady(r1_ready), .misaligned(r1_mis), .outOfRange(r1_oor)
  );

  data_memory_bytewise #(.DEPTH(32), .ADDR_WIDTH(32), .READ_LATENCY(2), .INIT_MODE(0)) dut2 (
    .clock(clock), .reset(rst2), .memRead(mem_read), .memWrite(mem_write),
    .accessSize(access_size), .loadUnsigned(load_unsigned), .address(address),
    .writeData(write_data), .readData(r2_data), .readValid(r2_valid),
    .memReady(r2_ready), .misaligned(r2_mis), .outOfRange(r2_oor)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [31:0] a, input logic [1:0] sz, input logic u);
    address       = a;
    access_size   = sz;
    load_unsigned = u;
  endtask

  task automatic rd1(input logic [31:0] a, input logic [1:0] sz, input logic u);
    set_req(a, sz, u);
    mem_read = 1'b1;
    step();
    mem_read = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d);
    set_req(a, sz, 1'b0);
    write_data = d;
    mem_write  = 1'b1;
    step();
    mem_write  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; load_unsigned = 1'b0;
    access_size = 2'b10; address = 32'h0; write_data = 32'h0;
    step(); step(); step();
    check_eq("reset_outputs", {r1_data, 27'h0, r1_valid, r1_ready, r1_mis, r1_oor, 1'b0},
             {32'h0, 32'h0});
    check_eq("reset_ready2", {31'h0, r2_ready}, 32'h0);

    // 1. Sweep length and first load
    rst = 1'b0; rst2 = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      n = i;
      if (r1_ready) break;
    end
    check_eq("sweep_cycles", 32'(n), 32'd32);
    check_eq("sweep_cycles2", {31'h0, r2_ready}, 32'h1);
    rd1(32'h0C, 2'b10, 1'b0);
    check_eq("lw_0c_valid", {31'h0, r1_valid}, 32'h1);
    check_eq("lw_0c_data", r1_data, 32'd3);
    step();
    check_eq("valid_pulse_end", {31'h0, r1_valid}, 32'h0);
    check_eq("data_hold", r1_data, 32'd3);

    // 2. Store word then sub-word loads
    wr(32'h10, 2'b10, 32'hDEADBEEF);
    check_eq("sw_flags", {30'h0, r1_mis, r1_oor}, 32'h0);
    rd1(32'h13, 2'b00, 1'b0); check_eq("lb_13", r1_data, 32'hFFFFFFDE);
    rd1(32'h13, 2'b00, 1'b1); check_eq("lbu_13", r1_data, 32'h000000DE);
    rd1(32'h10, 2'b01, 1'b0); check_eq("lh_10", r1_data, 32'hFFFFBEEF);
    rd1(32'h12, 2'b01, 1'b1); check_eq("lhu_12", r1_data, 32'h0000DEAD);
    rd1(32'h11, 2'b00, 1'b0); check_eq("lb_11", r1_data, 32'hFFFFFFBE);

    // 3. Lane-masked stores
    wr(32'h21, 2'b00, 32'hFFFFFF55);
    rd1(32'h20, 2'b10, 1'b0); check_eq("sb_21", r1_data, 32'h00005508);
    wr(32'h22, 2'b01, 32'h1234A5A5);
    rd1(32'h20, 2'b10, 1'b0); check_eq("sh_22", r1_data, 32'hA5A55508);

    // 4. Misaligned / out-of-range
    rd1(32'h02, 2'b10, 1'b0);
    check_eq("lw_02_flags", {29'h0, r1_valid, r1_mis, r1_oor}, 32'h6);
    check_eq("lw_02_data", r1_data, 32'h0);
    rd1(32'h11, 2'b01, 1'b0);
    check_eq("lh_11_flags", {29'h0, r1_valid, r1_mis, r1_oor}, 32'h6);
    rd1(32'h10, 2'b11, 1'b0);
    check_eq("size11_flags", {29'h0, r1_valid, r1_mis, r1_oor}, 32'h6);
    rd1(32'h1000, 2'b10, 1'b0);
    check_eq("lw_oor_flags", {29'h0, r1_valid, r1_mis, r1_oor}, 32'h5);
    check_eq("lw_oor_data", r1_data, 32'h0);
    wr(32'h80, 2'b10, 32'h0000FFFF);
    check_eq("sw_80_flags", {30'h0, r1_mis, r1_oor}, 32'h1);
    step();
    check_eq("oor_pulse_end", {31'h0, r1_oor}, 32'h0);
    wr(32'h06, 2'b10, 32'hCAFECAFE);
    check_eq("sw_06_flags", {30'h0, r1_mis, r1_oor}, 32'h2);
    rd1(32'h00, 2'b10, 1'b0); check_eq("lw_00_untouched", r1_data, 32'h0);
    rd1(32'h04, 2'b10, 1'b0); check_eq("lw_04_untouched", r1_data, 32'h1);

    // 5. Read-first on simultaneous read/write
    set_req(32'h04, 2'b10, 1'b0);
    write_data = 32'h00001234;
    mem_read = 1'b1; mem_write = 1'b1;
    step();
    mem_read = 1'b0; mem_write = 1'b0;
    check_eq("rw_same_old", r1_data, 32'd1);
    rd1(32'h04, 2'b10, 1'b0); check_eq("rw_same_new", r1_data, 32'h00001234);

    // 6. Two-cycle latency, back-to-back
    step();
    set_req(32'h0C, 2'b10, 1'b0); mem_read = 1'b1;
    step();
    check_eq("l2_not_yet", {31'h0, r2_valid}, 32'h0);
    set_req(32'h10, 2'b10, 1'b0);
    step();
    check_eq("l2_first", {r2_data[30:0], r2_valid}, {31'd3, 1'b1});
    set_req(32'h14, 2'b10, 1'b0);
    step();
    mem_read = 1'b0;
    check_eq("l2_second", r2_data, 32'hDEADBEEF);
    check_eq("l2_second_v", {31'h0, r2_valid}, 32'h1);
    step();
    check_eq("l2_third", {r2_data[30:0], r2_valid}, {31'd5, 1'b1});
    step();
    check_eq("l2_idle", {31'h0, r2_valid}, 32'h0);

    // Reset while reads are in flight
    set_req(32'h0C, 2'b10, 1'b0); mem_read = 1'b1;
    step(); step();
    mem_read = 1'b0;
    rst2 = 1'b1;
    #1;
    check_eq("midread_rst", {30'h0, r2_valid, r2_ready}, 32'h0);
    check_eq("midread_rst_data", r2_data, 32'h0);
    step();
    rst2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      seen = seen | r2_ready | r2_valid;
    end
    check_eq("sweep_partial", {31'h0, seen}, 32'h0);
    rst2 = 1'b1;
    step();
    rst2 = 1'b0;
    set_req(32'h10, 2'b10, 1'b0); mem_read = 1'b1;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      n = i;
      seen = seen | r2_valid;
      if (r2_ready) break;
    end
    mem_read = 1'b0;
    check_eq("resweep_cycles", 32'(n), 32'd32);
    check_eq("init_reads_ignored", {31'h0, seen}, 32'h0);
    step(); step();
    check_eq("init_reads_ignored2", {31'h0, r2_valid}, 32'h0);
    rd1(32'h10, 2'b10, 1'b0);
    step();
    check_eq("resweep_word4", r2_data, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
